x_500_mod_2011_loader: RTL and testbench
========================================

Name: x_500_mod_2011_loader

Overview:
Upstream feeder and result capture for the combinational x_500_mod_2011 reducer. It assembles a 500-bit operand from a narrow valid/ready word stream, least-significant word first, and holds it stable on x_out. It waits a fixed number of settle cycles, which makes the reducer a multicycle path, then registers the 11-bit residue and offers it on a valid/ready output. One operand is in flight at a time, with no overlap.

Parameters:
WORD_W, 32, input word width; legal values 8, 16, 32, 64.
SETTLE_CYCLES, 2, clocks x_out is held stable before r_in is sampled; range 1..15.
N_WORDS (localparam), ceil(500/WORD_W), beats per full operand; 16 at default.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
in_data  in  WORD_W  operand word.
in_valid  in  1  in_data valid.
in_last  in  1  final word of operand; qualified by in_valid.
in_ready  out  1  loader accepts a word.
x_out  out  500  assembled operand, to reducer X.
r_in  in  11  residue from reducer R.
r_out  out  11  registered residue.
out_valid  out  1  r_out valid.
out_ready  in  1  consumer accepts r_out.
busy  out  1  high in SETTLE and OUT.

Behaviour:
- Reset, asynchronous and active-high:
  - state LOAD, word count 0, x_out 0.
  - in_ready 1, out_valid 0, r_out 0, busy 0.
  - Any partial operand or pending result is discarded.
- LOAD:
  - in_ready=1.
  - Each accepted beat (in_valid & in_ready) writes in_data into x_out[cnt*WORD_W +: WORD_W]; count increments.
  - Bits above bit 499 are dropped; at default these are the upper 12 bits of word 15.
  - Leave LOAD for SETTLE when the accepted beat has in_last=1 or is beat N_WORDS-1, whichever comes first.
  - Words beyond an early in_last stay 0 (short operand = zero-extended).
  - in_last on beat N_WORDS-1 is equivalent to no in_last.
  - A beat with in_last beyond N_WORDS cannot occur, because the loader exits at N_WORDS.
- SETTLE:
  - in_ready=0, busy=1; x_out is not modified.
  - A down-counter is loaded with SETTLE_CYCLES on entry.
  - When it expires, r_in is registered into r_out, out_valid=1, and the state moves to OUT.
  - Latency: final beat accepted at edge t, so out_valid is high after edge t+SETTLE_CYCLES+1.
- OUT:
  - r_out, out_valid and x_out are held until out_valid & out_ready.
  - On that handshake: out_valid=0, x_out cleared to 0, count 0, state LOAD.
  - in_ready rises the following cycle; there is no same-cycle accept of a new word.
- in_valid while in_ready=0 is ignored; the word is neither stored nor lost, and the producer holds it.
- No combinational path exists from in_valid/out_ready to in_ready/out_valid; all outputs come from registers.
- r_in is trusted to be <2011; no correction is applied.

Optional Feature:
Macro X500_MOD_2011_TRUNC_CHECK_EN.
- Defined:
  - Adds output port trunc_err (1 bit, reset 0).
  - Set in the cycle after beat N_WORDS-1 is accepted if any in_data bit mapping above bit 499 was nonzero.
  - Held until the out handshake clears it, together with out_valid.
  - Residue is still computed on the truncated operand.
- Undefined: the port is absent and truncated bits are silently dropped.

Test Plan:
Bench connects x_out/r_in to the real x_500_mod_2011 reducer.
1. Assert rst mid-clock with no edge -> immediately in_ready=1, out_valid=0, r_out=0, x_out=0, busy=0.
2. 16 beats, word0=0x00000800, others 0, out_ready=1 -> r_out=37 (2048 mod 2011); out_valid exactly SETTLE_CYCLES+1 edges after beat 16.
3. Single beat word0=2011 with in_last=1 -> x_out=2011, r_out=0; then word0=2010 with in_last -> r_out=2010.
4. Backpressure:
   - out_ready=0 for 10 cycles with in_valid=1 -> r_out and x_out stable, in_ready=0, no words consumed.
   - out_ready=1 -> handshake, in_ready=1 next cycle.
5. Reset after 7 of 16 beats -> state LOAD, count 0; then word0=5 with in_last -> r_out=5 (no stale words).
6. With X500_MOD_2011_TRUNC_CHECK_EN: word15=0x80000000, others 0 -> trunc_err=1, r_out=0; word15=0x00080000 -> trunc_err=0, r_out=2^499 mod 2011 per golden model.

Source files
------------

// File: rtl/x_500_mod_2011_loader_if.sv
// Handshake and operand/residue bundle between a word producer, the loader and its consumer.
// The trunc_err signal exists only when X500_MOD_2011_TRUNC_CHECK_EN is defined.
interface x_500_mod_2011_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [499:0]      x_out;
  logic [10:0]       r_in;
  logic [10:0]       r_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
`ifdef X500_MOD_2011_TRUNC_CHECK_EN
  logic              trunc_err;

  modport slave (
    input  in_data, in_valid, in_last, r_in, out_ready,
    output in_ready, x_out, r_out, out_valid, busy, trunc_err
  );
  modport master (
    output in_data, in_valid, in_last, r_in, out_ready,
    input  in_ready, x_out, r_out, out_valid, busy, trunc_err
  );
`else
  modport slave (
    input  in_data, in_valid, in_last, r_in, out_ready,
    output in_ready, x_out, r_out, out_valid, busy
  );
  modport master (
    output in_data, in_valid, in_last, r_in, out_ready,
    input  in_ready, x_out, r_out, out_valid, busy
  );
`endif
endinterface

// File: rtl/x_500_mod_2011_loader.sv
// Assembles a 500-bit operand for the combinational mod-2011 reducer, waits out the multicycle
// settle window, then captures the residue. Optional X500_MOD_2011_TRUNC_CHECK_EN adds trunc_err.
module x_500_mod_2011_loader #(
  parameter int unsigned WORD_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                     clk,
  input logic                     rst,
  x_500_mod_2011_loader_if.slave  bus
);

  localparam int unsigned NWords = (500 + WORD_W - 1) / WORD_W;
  localparam int unsigned CntW   = $clog2(NWords);
  // Bits of the final word that still land inside the 500-bit operand
  localparam int unsigned LoBits = 500 - (NWords - 1) * WORD_W;

  typedef enum logic [1:0] {StLoad, StSettle, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      settle_q, settle_d;
  logic [499:0]    x_q, x_d;
  logic [10:0]     r_q, r_d;
  logic            accept;
  logic            last_beat;

  assign accept    = bus.in_valid && (state_q == StLoad);
  assign last_beat = (cnt_q == CntW'(NWords - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    x_d      = x_q;
    r_d      = r_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          for (int unsigned w = 0; w < NWords - 1; w++) begin
            if (cnt_q == CntW'(w)) x_d[w*WORD_W +: WORD_W] = bus.in_data;
          end
          if (last_beat) x_d[499 -: LoBits] = bus.in_data[LoBits-1:0];
          cnt_d = cnt_q + 1'b1;
          if (bus.in_last || last_beat) begin
            state_d  = StSettle;
            settle_d = 4'(SETTLE_CYCLES);
          end
        end
      end
      StSettle: begin
        // Count reaches zero SETTLE_CYCLES edges after entry; sample on the edge after that
        if (settle_q == 4'd0) begin
          r_d     = bus.r_in;
          state_d = StOut;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StLoad;
          cnt_d   = '0;
          x_d     = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      settle_q <= '0;
      x_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      x_q      <= x_d;
      r_q      <= r_d;
    end
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.out_valid = (state_q == StOut);
  assign bus.busy      = (state_q != StLoad);
  assign bus.x_out     = x_q;
  assign bus.r_out     = r_q;

`ifdef X500_MOD_2011_TRUNC_CHECK_EN
  logic trunc_q, trunc_d;

  always_comb begin
    trunc_d = trunc_q;
    if (accept && last_beat) begin
      trunc_d = |bus.in_data[WORD_W-1:LoBits];
    end else if ((state_q == StOut) && bus.out_ready) begin
      trunc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trunc_q <= 1'b0;
    else     trunc_q <= trunc_d;
  end

  assign bus.trunc_err = trunc_q;
`endif

endmodule

// File: tb/tb_x_500_mod_2011_loader.sv
// Scoreboard bench for x_500_mod_2011_loader; a behavioural mod-2011 reducer closes the loop.
module tb_x_500_mod_2011_loader;

  localparam int unsigned WordW  = 32;
  localparam int unsigned Settle = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  x_500_mod_2011_loader_if #(.WORD_W(WordW)) bus ();

  x_500_mod_2011_loader #(
    .WORD_W        (WordW),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [10:0] exp_q[$];

  function automatic logic [10:0] mod2011(input logic [499:0] x);
    int unsigned r = 0;
    for (int i = 499; i >= 0; i--) r = (r * 2 + 32'(x[i])) % 2011;
    return 11'(r);
  endfunction

  always_comb bus.r_in = mod2011(bus.x_out);

  function automatic void chk(input string name, input logic [511:0] act,
                              input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Result monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected actual=%0d required=none", bus.r_out);
      end else begin
        chk("sb_r_out", 512'(bus.r_out), 512'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 512'(bus.in_ready), 512'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 512'(bus.out_valid), 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [499:0] v;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Partial operand, then asynchronous reset between edges
    for (int i = 0; i < 3; i++) send(32'hffff_ffff, 1'b0);
    chk("t1_x_pre", 512'(bus.x_out), 512'({404'b0, {96{1'b1}}}));
    #2;
    rst = 1'b1;
    #1;
    chk("t1_in_ready", 512'(bus.in_ready), 512'(1));
    chk("t1_out_valid", 512'(bus.out_valid), 512'(0));
    chk("t1_r_out", 512'(bus.r_out), 512'(0));
    chk("t1_x_out", 512'(bus.x_out), 512'(0));
    chk("t1_busy", 512'(bus.busy), 512'(0));
    @(negedge clk);
    rst = 1'b0;

    // Full 16-beat operand, exit on count, latency check
    exp_q.push_back(11'd37);
    send(32'h0000_0800, 1'b0);
    for (int i = 1; i < 16; i++) send(32'h0, 1'b0);
    chk("t2_busy", 512'(bus.busy), 512'(1));
    chk("t2_in_ready", 512'(bus.in_ready), 512'(0));
    for (int k = 1; k <= Settle; k++) begin
      @(posedge clk);
      #1;
      chk("t2_early_valid", 512'(bus.out_valid), 512'(0));
    end
    @(posedge clk);
    #1;
    chk("t2_valid_on_time", 512'(bus.out_valid), 512'(1));
    chk("t2_x_out", 512'(bus.x_out), 512'(2048));
    @(posedge clk);
    #1;
    chk("t2_valid_drop", 512'(bus.out_valid), 512'(0));
    chk("t2_in_ready_back", 512'(bus.in_ready), 512'(1));
    chk("t2_x_cleared", 512'(bus.x_out), 512'(0));

    // Single-beat operands around the modulus
    exp_q.push_back(11'd0);
    send(32'd2011, 1'b1);
    wait_valid("t3a_wait");
    chk("t3a_x_out", 512'(bus.x_out), 512'(2011));
    @(posedge clk);
    #1;
    exp_q.push_back(11'd2010);
    send(32'd2010, 1'b1);
    wait_valid("t3b_wait");
    chk("t3b_x_out", 512'(bus.x_out), 512'(2010));
    @(posedge clk);
    #1;

    // Output backpressure with a producer holding a word
    bus.out_ready = 1'b0;
    exp_q.push_back(11'd638);
    send(32'h0000_1234, 1'b1);
    wait_valid("t4_wait");
    exp_q.push_back(11'd697);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_dead;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t4_r_hold", 512'(bus.r_out), 512'(638));
      chk("t4_x_hold", 512'(bus.x_out), 512'(32'h1234));
      chk("t4_in_ready_low", 512'(bus.in_ready), 512'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_valid_drop", 512'(bus.out_valid), 512'(0));
    chk("t4_in_ready_back", 512'(bus.in_ready), 512'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("t4_held_taken", 512'(bus.busy), 512'(1));
    wait_valid("t4b_wait");
    chk("t4b_x_out", 512'(bus.x_out), 512'(32'hdead));
    @(posedge clk);
    #1;

    // Reset mid-operand discards the stale words
    for (int i = 0; i < 7; i++) send(32'h1111_1111 * (i + 1), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_in_ready", 512'(bus.in_ready), 512'(1));
    chk("t5_x_out", 512'(bus.x_out), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(11'd5);
    send(32'd5, 1'b1);
    wait_valid("t5_wait");
    chk("t5_x_after", 512'(bus.x_out), 512'(5));
    @(posedge clk);
    #1;

`ifdef X500_MOD_2011_TRUNC_CHECK_EN
    exp_q.push_back(11'd0);
    for (int i = 0; i < 15; i++) send(32'h0, 1'b0);
    send(32'h8000_0000, 1'b0);
    wait_valid("t6a_wait");
    chk("t6a_trunc", 512'(bus.trunc_err), 512'(1));
    chk("t6a_x_out", 512'(bus.x_out), 512'(0));
    @(posedge clk);
    #1;
    chk("t6a_trunc_clr", 512'(bus.trunc_err), 512'(0));
    v      = '0;
    v[499] = 1'b1;
    exp_q.push_back(mod2011(v));
    for (int i = 0; i < 15; i++) send(32'h0, 1'b0);
    send(32'h0008_0000, 1'b0);
    wait_valid("t6b_wait");
    chk("t6b_trunc", 512'(bus.trunc_err), 512'(0));
    chk("t6b_x_out", 512'(bus.x_out), 512'(v));
    @(posedge clk);
    #1;
`else
    v = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 512'(exp_q.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
